// File: rtl/pe_store_unit.sv
// pe_store_unit: write-back engine for the PE array.
// A start pulse snapshots the four PE result words, the lane mask and the
// base address; the selected words are then written one per cycle to BRAM
// port B at consecutive addresses, and a one-cycle done pulse closes the
// operation.
module pe_store_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int BASE_W = 17,
  parameter int N_PE   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              STORE_START,
  input  logic [BASE_W-1:0] BASE_ADDR,
  input  logic [N_PE-1:0]   PE_MASK,
  input  logic [DATA_W-1:0] PE_DOUT_0,
  input  logic [DATA_W-1:0] PE_DOUT_1,
  input  logic [DATA_W-1:0] PE_DOUT_2,
  input  logic [DATA_W-1:0] PE_DOUT_3,
  input  logic              WR_STALL,
  output logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] dinb,
  output logic              enb,
  output logic [3:0]        web,
  output logic              STORE_BUSY,
  output logic              STORE_DONE,
  output logic [2:0]        STORE_CNT
);

  localparam int SEL_W = $clog2(N_PE);
  localparam logic [N_PE-1:0] ONE = N_PE'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] snap [N_PE];
  logic [N_PE-1:0]   pend;
  logic [BASE_W-1:0] base;
  logic [2:0]        offset;
  logic [SEL_W-1:0]  sel;
  logic              last;

  // Pick the lowest pending lane and detect whether it is the final one.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    sel  = '0;
    for (int i = N_PE - 1; i >= 0; i--) begin
      if (pend[i]) sel = SEL_W'(i);
    end
    last = (pend & (pend - ONE)) == '0;
  end

  // Control FSM, snapshot registers and registered BRAM port-B outputs.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (RST) begin
      state      <= S_IDLE;
      for (int i = 0; i < N_PE; i++) snap[i] <= '0;
      pend       <= '0;
      base       <= '0;
      offset     <= '0;
      addrb      <= '0;
      dinb       <= '0;
      enb        <= 1'b0;
      web        <= 4'b0000;
      STORE_BUSY <= 1'b0;
      STORE_DONE <= 1'b0;
      STORE_CNT  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          enb        <= 1'b0;
          web        <= 4'b0000;
          STORE_DONE <= 1'b0;
          // A start arriving while the done pulse is on the outputs is dropped.
          if (STORE_START && !STORE_DONE) begin
            snap[0]    <= PE_DOUT_0;
            snap[1]    <= PE_DOUT_1;
            snap[2]    <= PE_DOUT_2;
            snap[3]    <= PE_DOUT_3;
            pend       <= PE_MASK;
            base       <= BASE_ADDR;
            offset     <= '0;
            STORE_CNT  <= '0;
            STORE_BUSY <= 1'b1;
            state      <= (PE_MASK == '0) ? S_DONE : S_WRITE;
          end else begin
            STORE_BUSY <= 1'b0;
          end
        end

        S_WRITE: begin
          STORE_DONE <= 1'b0;
          if (!WR_STALL) begin
            addrb     <= ADDR_W'(base) + ADDR_W'(offset);
            dinb      <= snap[sel];
            enb       <= 1'b1;
            web       <= 4'b1111;
            pend      <= pend & (pend - ONE);
            offset    <= offset + 3'd1;
            STORE_CNT <= STORE_CNT + 3'd1;
            if (last) state <= S_DONE;
          end else begin
            enb <= 1'b0;
            web <= 4'b0000;
          end
        end

        S_DONE: begin
          enb        <= 1'b0;
          web        <= 4'b0000;
          STORE_DONE <= 1'b1;
          state      <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_store_unit.sv
// tb_pe_store_unit: directed self-checking bench for pe_store_unit with
// hand-computed expected write sequences, latencies and done timing.
module tb_pe_store_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        STORE_START;
  logic [16:0] BASE_ADDR;
  logic [3:0]  PE_MASK;
  logic [31:0] PE_DOUT_0, PE_DOUT_1, PE_DOUT_2, PE_DOUT_3;
  logic        WR_STALL;
  logic [31:0] addrb;
  logic [31:0] dinb;
  logic        enb;
  logic [3:0]  web;
  logic        STORE_BUSY;
  logic        STORE_DONE;
  logic [2:0]  STORE_CNT;

  int checks = 0;
  int errors = 0;

  pe_store_unit dut (
    .CLK         (CLK),
    .RST         (RST),
    .STORE_START (STORE_START),
    .BASE_ADDR   (BASE_ADDR),
    .PE_MASK     (PE_MASK),
    .PE_DOUT_0   (PE_DOUT_0),
    .PE_DOUT_1   (PE_DOUT_1),
    .PE_DOUT_2   (PE_DOUT_2),
    .PE_DOUT_3   (PE_DOUT_3),
    .WR_STALL    (WR_STALL),
    .addrb       (addrb),
    .dinb        (dinb),
    .enb         (enb),
    .web         (web),
    .STORE_BUSY  (STORE_BUSY),
    .STORE_DONE  (STORE_DONE),
    .STORE_CNT   (STORE_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Check the full output state; address/data only matter on write cycles.
  task automatic expect_out(input string tag, input logic en, input logic [31:0] addr,
                            input logic [31:0] data, input logic busy, input logic done,
                            input logic [2:0] cnt);
    check({tag, ".enb"},  32'(enb), 32'(en));
    check({tag, ".web"},  32'(web), en ? 32'hF : 32'h0);
    if (en) begin
      check({tag, ".addrb"}, addrb, addr);
      check({tag, ".dinb"},  dinb,  data);
    end
    check({tag, ".busy"}, 32'(STORE_BUSY), 32'(busy));
    check({tag, ".done"}, 32'(STORE_DONE), 32'(done));
    check({tag, ".cnt"},  32'(STORE_CNT),  32'(cnt));
  endtask

  task automatic set_pe(input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3);
    PE_DOUT_0 = d0;
    PE_DOUT_1 = d1;
    PE_DOUT_2 = d2;
    PE_DOUT_3 = d3;
  endtask

  // Present a start with the given operands; the returned edge is edge 0.
  task automatic start_op(input logic [16:0] base, input logic [3:0] mask);
    BASE_ADDR   = base;
    PE_MASK     = mask;
    STORE_START = 1'b1;
    tick();
    STORE_START = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    STORE_START = 1'b0;
    BASE_ADDR = '0;
    PE_MASK = '0;
    WR_STALL = 1'b0;
    set_pe(32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    check("rst.addrb", addrb, 32'h0);
    check("rst.dinb",  dinb,  32'h0);
    expect_out("rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0);
    RST = 1'b0;
    tick();

    // 1. Full mask, no stall.
    set_pe(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    start_op(17'h100, 4'b1111);
    expect_out("full.e0", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 3'd0);
    for (int j = 1; j <= 4; j++) begin
      tick();
      expect_out($sformatf("full.e%0d", j), 1'b1, 32'h100 + 32'(j - 1), 32'hA0 + 32'(j - 1),
                 1'b1, 1'b0, 3'(j));
    end
    tick();
    expect_out("full.e5", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 3'd4);
    check("full.e5.addr_hold", addrb, 32'h103);
    check("full.e5.data_hold", dinb,  32'hA3);
    tick();
    expect_out("full.e6", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd4);

    // 2. Sparse mask 1010: PE1 then PE3, packed.
    set_pe(32'hB0, 32'hB1, 32'hB2, 32'hB3);
    start_op(17'h20, 4'b1010);
    tick();
    expect_out("sparse.e1", 1'b1, 32'h20, 32'hB1, 1'b1, 1'b0, 3'd1);
    tick();
    expect_out("sparse.e2", 1'b1, 32'h21, 32'hB3, 1'b1, 1'b0, 3'd2);
    tick();
    expect_out("sparse.e3", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 3'd2);
    tick();
    expect_out("sparse.e4", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd2);

    // 3. Zero mask: no writes, done after edge 1.
    start_op(17'h55, 4'b0000);
    expect_out("zero.e0", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 3'd0);
    tick();
    expect_out("zero.e1", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 3'd0);
    tick();
    expect_out("zero.e2", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0);

    // 4. Full mask with stall on edges 2-3.
    set_pe(32'hC0, 32'hC1, 32'hC2, 32'hC3);
    start_op(17'h40, 4'b1111);
    tick();
    expect_out("stall.e1", 1'b1, 32'h40, 32'hC0, 1'b1, 1'b0, 3'd1);
    WR_STALL = 1'b1;
    tick();
    expect_out("stall.e2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 3'd1);
    tick();
    expect_out("stall.e3", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 3'd1);
    WR_STALL = 1'b0;
    for (int j = 4; j <= 6; j++) begin
      tick();
      expect_out($sformatf("stall.e%0d", j), 1'b1, 32'h40 + 32'(j - 3), 32'hC0 + 32'(j - 3),
                 1'b1, 1'b0, 3'(j - 2));
    end
    tick();
    expect_out("stall.e7", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 3'd4);
    tick();

    // 5. Snapshot isolation, start while busy and start during done are ignored.
    set_pe(32'hD0, 32'hD1, 32'hD2, 32'hD3);
    start_op(17'h200, 4'b1111);
    tick();
    expect_out("snap.e1", 1'b1, 32'h200, 32'hD0, 1'b1, 1'b0, 3'd1);
    set_pe(32'hEE0, 32'hEE1, 32'hEE2, 32'hEE3);
    BASE_ADDR = 17'h1F00;
    PE_MASK = 4'b0001;
    STORE_START = 1'b1;
    tick();
    STORE_START = 1'b0;
    expect_out("snap.e2", 1'b1, 32'h201, 32'hD1, 1'b1, 1'b0, 3'd2);
    tick();
    expect_out("snap.e3", 1'b1, 32'h202, 32'hD2, 1'b1, 1'b0, 3'd3);
    tick();
    expect_out("snap.e4", 1'b1, 32'h203, 32'hD3, 1'b1, 1'b0, 3'd4);
    tick();
    expect_out("snap.e5", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 3'd4);
    PE_MASK = 4'b1111;
    STORE_START = 1'b1;
    tick();
    STORE_START = 1'b0;
    expect_out("snap.e6_done_start", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd4);
    tick();
    expect_out("snap.e7", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd4);

    // 6. Reset mid-operation, then a clean operation.
    set_pe(32'hE0, 32'hE1, 32'hE2, 32'hE3);
    start_op(17'h300, 4'b1111);
    tick();
    expect_out("rstmid.e1", 1'b1, 32'h300, 32'hE0, 1'b1, 1'b0, 3'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    expect_out("rstmid.e2", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0);
    check("rstmid.e2.addrb", addrb, 32'h0);
    check("rstmid.e2.dinb",  dinb,  32'h0);
    for (int j = 3; j <= 6; j++) begin
      tick();
      expect_out($sformatf("rstmid.e%0d", j), 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0);
    end
    set_pe(32'h77, 32'h1, 32'h2, 32'h3);
    start_op(17'h5, 4'b0001);
    tick();
    expect_out("after.e1", 1'b1, 32'h5, 32'h77, 1'b1, 1'b0, 3'd1);
    tick();
    expect_out("after.e2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 3'd1);
    tick();
    expect_out("after.e3", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
